// File: rtl/alu_exec_iter.sv
// alu_exec_iter: RV32I execute-stage ALU with valid/ready handshakes.
// Evaluates integer ops and branch conditions from the 4-bit ALU control code.
// Shifts are iterative (one bit per cycle) by default. Defining
// ALU_BARREL_SHIFT_EN replaces them with a single-cycle barrel shifter.
module alu_exec_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic            is_branch,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SW = $clog2(XLEN);

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } sh_kind_e;
`endif

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;
  logic            zero_q, zero_d;

`ifndef ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0] work_q, work_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  sh_kind_e        kind_q, kind_d;
  logic [XLEN-1:0] work_step_c;
`endif

  logic            accept_c;
  logic [XLEN-1:0] sum_c;
  logic [XLEN-1:0] diff_c;
  logic            eq_c;
  logic            lt_s_c;
  logic            lt_u_c;
  logic [SW-1:0]   shamt_c;

  // Request acceptance: only in IDLE and never while reset is asserted.
  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign accept_c     = in_valid && in_ready;

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign illegal      = illegal_q;
  assign zero         = zero_q;

  // Shared arithmetic and comparison datapath on the incoming operands.
  always_comb begin
    sum_c   = op_a + op_b;
    diff_c  = op_a - op_b;
    eq_c    = (op_a == op_b);
    lt_s_c  = ($signed(op_a) < $signed(op_b));
    lt_u_c  = (op_a < op_b);
    shamt_c = op_b[SW-1:0];
  end

`ifndef ALU_BARREL_SHIFT_EN
  // One-bit shift of the working register; SRA replicates the sign bit.
  always_comb begin
    work_step_c = work_q;
    case (kind_q)
      SH_SLL:  work_step_c = {work_q[XLEN-2:0], 1'b0};
      SH_SRL:  work_step_c = {1'b0, work_q[XLEN-1:1]};
      SH_SRA:  work_step_c = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: work_step_c = work_q;
    endcase
  end
`endif

  // Next-state and output computation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
    work_d      = work_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = '0;
          taken_d     = 1'b0;
          illegal_d   = 1'b0;
          if (is_branch) begin
            case (alu_ctrl)
              4'b1000: taken_d = eq_c;
              4'b1001: taken_d = !eq_c;
              4'b1100: taken_d = lt_s_c;
              4'b1101: taken_d = !lt_s_c;
              4'b1110: taken_d = lt_u_c;
              4'b1111: taken_d = !lt_u_c;
              default: illegal_d = 1'b1;
            endcase
          end else begin
            case (alu_ctrl)
              4'b0000: result_d = sum_c;
              4'b1000: result_d = diff_c;
              4'b0010: result_d = XLEN'(lt_s_c);
              4'b0011: result_d = XLEN'(lt_u_c);
              4'b0100: result_d = op_a ^ op_b;
              4'b0110: result_d = op_a | op_b;
              4'b0111: result_d = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
              4'b0001: result_d = op_a << shamt_c;
              4'b0101: result_d = op_a >> shamt_c;
              4'b1101: result_d = $unsigned($signed(op_a) >>> shamt_c);
`else
              4'b0001, 4'b0101, 4'b1101: begin
                if (shamt_c == '0) begin
                  result_d = op_a;
                end else begin
                  state_d     = S_SHIFT;
                  out_valid_d = 1'b0;
                  work_d      = op_a;
                  cnt_d       = shamt_c;
                  case (alu_ctrl)
                    4'b0001: kind_d = SH_SLL;
                    4'b0101: kind_d = SH_SRL;
                    default: kind_d = SH_SRA;
                  endcase
                end
              end
`endif
              default: illegal_d = 1'b1;
            endcase
          end
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      S_SHIFT: begin
        work_d = work_step_c;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = work_step_c;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    zero_d = (result_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      zero_q      <= zero_d;
    end
  end

`ifndef ALU_BARREL_SHIFT_EN
  // Iterative shifter working register, remaining count and shift kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_SLL;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_iter.sv
// Self-checking bench for alu_exec_iter using a scoreboard of expected results.
module tb_alu_exec_iter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic            is_branch;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            zero;
  logic            illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        taken;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_exec_iter #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_ctrl     (alu_ctrl),
    .is_branch    (is_branch),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .zero         (zero),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected result, branch outcome, illegal flag and latency.
  function automatic exp_t model(input logic [3:0] c, input logic br,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    logic is_sh;
    sh      = int'(b[4:0]);
    is_sh   = 1'b0;
    e.res   = 32'h0;
    e.taken = 1'b0;
    e.ill   = 1'b0;
    if (br) begin
      case (c)
        4'h8: e.taken = (a == b);
        4'h9: e.taken = (a != b);
        4'hC: e.taken = ($signed(a) < $signed(b));
        4'hD: e.taken = ($signed(a) >= $signed(b));
        4'hE: e.taken = (a < b);
        4'hF: e.taken = (a >= b);
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (c)
        4'h0: e.res = a + b;
        4'h8: e.res = a - b;
        4'h2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'h3: e.res = (a < b) ? 32'd1 : 32'd0;
        4'h4: e.res = a ^ b;
        4'h6: e.res = a | b;
        4'h7: e.res = a & b;
        4'h1: begin e.res = a << sh; is_sh = 1'b1; end
        4'h5: begin e.res = a >> sh; is_sh = 1'b1; end
        4'hD: begin e.res = $unsigned($signed(a) >>> sh); is_sh = 1'b1; end
        default: e.ill = 1'b1;
      endcase
    end
`ifdef ALU_BARREL_SHIFT_EN
    e.lat = 1;
`else
    e.lat = (is_sh && sh != 0) ? sh + 1 : 1;
`endif
    return e;
  endfunction

  // Drive one request, wait (bounded) for acceptance and push its expectation.
  task automatic issue(input logic [3:0] c, input logic br,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    alu_ctrl  = c;
    is_branch = br;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(model(c, br, a, b));
  endtask

  // Count cycles from the accept edge until out_valid; -1 if it never comes.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  // Complete the output handshake with a single-cycle out_ready pulse.
  task automatic finish_hs();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (branch_taken !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_flags: taken=%b illegal=%b expected 0 0", branch_taken, illegal); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  tc [12] = '{4'h0, 4'h8, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hB, 4'h9, 4'hE, 4'hA};
    logic [31:0] ta [12] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h12340000,
                             32'hFF00FF00, 32'h0, 32'h1234, 32'hDEADBEEF, 32'h1, 32'h2};
    logic [31:0] tb [12] = '{32'h1, 32'h5, 32'h1, 32'h1, 32'hFFFF0000, 32'h00005678,
                             32'h0F0F0F0F, 32'h1, 32'h5678, 32'h1, 32'h2, 32'h3};
    logic [3:0]  legal [10] = '{4'h0, 4'h8, 4'h1, 4'h5, 4'hD, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7};
    exp_t        e;
    int          lat;
    logic [3:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      if (i < 12) begin
        c = tc[i]; a = ta[i]; b = tb[i];
      end else begin
        c = legal[$urandom_range(9)]; a = $urandom; b = $urandom;
      end
      issue(c, 1'b0, a, b);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin failures++; $display("FAIL alu_latency[%0d] code=%h: got %0d expected %0d", i, c, lat, e.lat); end
      checks++; if (result !== e.res) begin failures++; $display("FAIL alu_result[%0d] code=%h a=%h b=%h: got %h expected %h", i, c, a, b, result, e.res); end
      checks++; if (illegal !== e.ill || branch_taken !== 1'b0) begin failures++; $display("FAIL alu_flags[%0d] code=%h: illegal=%b taken=%b expected %b 0", i, c, illegal, branch_taken, e.ill); end
      checks++; if (zero !== (e.res == 32'h0)) begin failures++; $display("FAIL alu_zero[%0d] code=%h: got %b expected %b", i, c, zero, (e.res == 32'h0)); end
      finish_hs();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  tc [5] = '{4'hD, 4'h1, 4'h5, 4'h1, 4'hD};
    logic [31:0] ta [5] = '{32'h80000000, 32'h3, 32'h80000000, 32'h1, 32'h7FFFFFFF};
    logic [31:0] tb [5] = '{32'h00000024, 32'hFFFFFFE0, 32'h0000001F, 32'h0000001F, 32'h00000043};
    exp_t        e;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      issue(tc[i], 1'b0, ta[i], tb[i]);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin failures++; $display("FAIL shift_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (result !== e.res) begin failures++; $display("FAIL shift_result[%0d] code=%h a=%h b=%h: got %h expected %h", i, tc[i], ta[i], tb[i], result, e.res); end
      checks++; if (zero !== (e.res == 32'h0) || illegal !== 1'b0) begin failures++; $display("FAIL shift_flags[%0d]: zero=%b illegal=%b", i, zero, illegal); end
      finish_hs();
    end
  endtask

  task automatic test_branch();
    logic [3:0]  tc [10] = '{4'hC, 4'hE, 4'hA, 4'h8, 4'h9, 4'hD, 4'hF, 4'hB, 4'h0, 4'h8};
    logic [31:0] ta [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h7, 32'h7, 32'hFFFFFFFF,
                             32'h1, 32'h1, 32'h1, 32'h7};
    logic [31:0] tb [10] = '{32'h1, 32'h1, 32'h1, 32'h7, 32'h7, 32'h1,
                             32'hFFFFFFFF, 32'h2, 32'h1, 32'h8};
    exp_t        e;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      issue(tc[i], 1'b1, ta[i], tb[i]);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != 1) begin failures++; $display("FAIL branch_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (branch_taken !== e.taken) begin failures++; $display("FAIL branch_taken[%0d] code=%h: got %b expected %b", i, tc[i], branch_taken, e.taken); end
      checks++; if (illegal !== e.ill) begin failures++; $display("FAIL branch_illegal[%0d] code=%h: got %b expected %b", i, tc[i], illegal, e.ill); end
      checks++; if (result !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL branch_result[%0d]: result=%h zero=%b expected 00000000 1", i, result, zero); end
      finish_hs();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    issue(4'h4, 1'b0, 32'hF0F0F0F0, 32'hFFFF0000);
    wait_out(lat);
    e = sb.pop_front();
    checks++; if (lat != 1) begin failures++; $display("FAIL bp_latency: got %0d expected 1", lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_ctrl  = 4'h0;
      is_branch = 1'b0;
      op_a      = 32'h1;
      op_b      = 32'h1;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || result !== e.res) begin failures++; $display("FAIL bp_hold[%0d]: out_valid=%b result=%h expected 1 %h", i, out_valid, result, e.res); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: out_valid=%b expected 0", out_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_ignored: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] legal [10] = '{4'h0, 4'h8, 4'h1, 4'h5, 4'hD, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7};
    exp_t        e;
    int          lat;
    logic [3:0]  c;
    logic [31:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = legal[$urandom_range(9)];
      a = $urandom;
      b = $urandom_range(40);
      issue(c, 1'b0, a, b);
      wait_out(lat);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin failures++; $display("FAIL b2b_latency[%0d] code=%h: got %0d expected %0d", i, c, lat, e.lat); end
      checks++; if (result !== e.res) begin failures++; $display("FAIL b2b_result[%0d] code=%h a=%h b=%h: got %h expected %h", i, c, a, b, result, e.res); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    issue(4'h1, 1'b0, 32'h00000001, 32'h00000014);
    repeat (4) @(posedge clk);
    #1;
`ifndef ALU_BARREL_SHIFT_EN
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midshift_busy: out_valid=%b expected 0", out_valid); end
`endif
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    checks++; if (out_valid !== 1'b0 || result !== 32'h0) begin failures++; $display("FAIL midshift_reset: out_valid=%b result=%h expected 0 00000000", out_valid, result); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midshift_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midshift_release: in_ready=%b expected 1", in_ready); end
    repeat (25) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midshift_lost: out_valid=%b expected 0", out_valid); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'h0;
    is_branch = 1'b0;
    op_a      = '0;
    op_b      = '0;
    test_reset();
    test_alu_ops();
    test_shift();
    test_branch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
